// File: rtl/fp_mul_booth_seq.sv
// Sequential radix-4 Booth multiplier for 24-bit significands.
// Retires one Booth digit per cycle and holds the 48-bit product until it is taken.
module fp_mul_booth_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [22:0] frc_X,
   input  logic [22:0] frc_Y,
   input  logic        hid_X,
   input  logic        hid_Y,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [47:0] frc_Z_full,
   output logic        busy,
   output logic [1:0]  state_dbg
);

   // Handshake: a transfer happens on a rising edge where valid && ready are both high;
   // valid is never withdrawn by the producer before that edge, and data is stable while valid.
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [49:0] m_sh_q, m_sh_d;
   logic [26:0] q_sh_q, q_sh_d;
   logic [49:0] acc_q, acc_d;
   logic        out_valid_q, out_valid_d;
   logic        busy_q, busy_d;
   logic        idle_q, idle_d;

   logic [2:0]  triple;
   logic [49:0] pp_mag;
   logic [49:0] addend;
   logic [49:0] sum;
   logic        neg;

   always_comb begin
      // q_sh_q[0] is the Q[2i-1] bit of the current triple
      triple = q_sh_q[2:0];
      pp_mag = '0;
      neg    = 1'b0;
      case (triple)
         3'b001, 3'b010: pp_mag = m_sh_q;
         3'b011:         pp_mag = m_sh_q << 1;
         3'b100:         begin pp_mag = m_sh_q << 1; neg = 1'b1; end
         3'b101, 3'b110: begin pp_mag = m_sh_q;      neg = 1'b1; end
         default:        pp_mag = '0;
      endcase
      addend = neg ? ~pp_mag : pp_mag;
      sum    = acc_q + addend + {49'b0, neg};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      m_sh_d  = m_sh_q;
      q_sh_d  = q_sh_q;
      acc_d   = acc_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               m_sh_d  = {26'b0, hid_X, frc_X};
               q_sh_d  = {2'b0, hid_Y, frc_Y, 1'b0};
               acc_d   = '0;
               cnt_d   = 4'd0;
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d  = sum;
            m_sh_d = m_sh_q << 2;
            q_sh_d = q_sh_q >> 2;
            if (cnt_q == 4'd12) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d == CALC);
      idle_d      = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         m_sh_q      <= '0;
         q_sh_q      <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         idle_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         m_sh_q      <= m_sh_d;
         q_sh_q      <= q_sh_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         idle_q      <= idle_d;
      end
   end

   // Gated by rst so nothing is offered while reset is held.
   assign in_ready   = idle_q & ~rst;
   assign out_valid  = out_valid_q;
   assign busy       = busy_q;
   assign frc_Z_full = acc_q[47:0];
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_fp_mul_booth_seq.sv
// Directed bench for fp_mul_booth_seq: products, latency, back-pressure, reset abort.
module tb_fp_mul_booth_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [22:0] frc_X;
   logic [22:0] frc_Y;
   logic        hid_X;
   logic        hid_Y;
   logic        out_valid;
   logic        out_ready;
   logic [47:0] frc_Z_full;
   logic        busy;
   logic [1:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   fp_mul_booth_seq dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .frc_X      (frc_X),
      .frc_Y      (frc_Y),
      .hid_X      (hid_X),
      .hid_Y      (hid_Y),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .frc_Z_full (frc_Z_full),
      .busy       (busy),
      .state_dbg  (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one operation, scramble inputs while it runs, optionally stall, then take the result.
   task automatic do_op(input string tag, input logic hx, input logic [22:0] fx,
                        input logic hy, input logic [22:0] fy,
                        input logic [47:0] exp, input int stall);
      int lat;
      lat = 99;
      @(negedge clk);
      hid_X = hx; frc_X = fx; hid_Y = hy; frc_Y = fy;
      in_valid = 1'b1;
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      for (int k = 1; k <= 30; k++) begin
         frc_X = 23'($urandom); frc_Y = 23'($urandom);
         hid_X = 1'($urandom);  hid_Y = 1'($urandom);
         @(posedge clk);
         @(negedge clk);
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      in_valid = 1'b0;
      chk({tag, "_latency"}, 64'(lat), 64'd13);
      chk({tag, "_product"}, 64'(frc_Z_full), 64'(exp));
      chk({tag, "_no_ready_in_done"}, 64'(in_ready), 64'd0);
      for (int s = 0; s < stall; s++) begin
         frc_X = ~frc_X;
         @(posedge clk);
         @(negedge clk);
         chk({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
         chk({tag, "_stall_product"}, 64'(frc_Z_full), 64'(exp));
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
      chk({tag, "_ready_back"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      int seen;
      logic [47:0] exp_sub;
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      hid_X = 1'b1; frc_X = '0; hid_Y = 1'b1; frc_Y = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_product", 64'(frc_Z_full), 64'd0);
      chk("rst_state", 64'(state_dbg), 64'd0);
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      chk("post_rst_out_valid", 64'(out_valid), 64'd0);

      do_op("one_x_one", 1'b1, 23'h0, 1'b1, 23'h0, 48'h400000000000, 0);
      do_op("max_x_max", 1'b1, 23'h7FFFFF, 1'b1, 23'h7FFFFF, 48'hFFFFFE000001, 0);
      chk("max_x_max_bit47", 64'(frc_Z_full[47]), 64'd1);
      do_op("1p5_x_1p5", 1'b1, 23'h400000, 1'b1, 23'h400000, 48'h900000000000, 0);
      do_op("one_x_pi", 1'b1, 23'h0, 1'b1, 23'h490FDB, 48'h6487ED800000, 0);
      chk("one_x_pi_frac", 64'(frc_Z_full[45:23]), 64'h490FDB);
      chk("one_x_pi_bit46", 64'(frc_Z_full[46]), 64'd1);
      exp_sub = 48'h2DF854 * 48'hC90FDB;
      do_op("sub_x_pi", 1'b0, 23'h2DF854, 1'b1, 23'h490FDB, exp_sub, 0);
      do_op("zero_x_pi", 1'b0, 23'h0, 1'b1, 23'h490FDB, 48'h0, 0);
      do_op("max_x_zero", 1'b1, 23'h7FFFFF, 1'b0, 23'h0, 48'h0, 0);
      do_op("stall", 1'b1, 23'h400000, 1'b1, 23'h400000, 48'h900000000000, 5);

      // abort mid-calculation at counter 6
      @(negedge clk);
      hid_X = 1'b1; frc_X = 23'h7FFFFF; hid_Y = 1'b1; frc_Y = 23'h7FFFFF;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("abort_busy_before", 64'(busy), 64'd1);
      rst = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_product", 64'(frc_Z_full), 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd0);
      chk("abort_state", 64'(state_dbg), 64'd0);
      rst = 1'b0; out_ready = 1'b0;
      #1;
      chk("abort_release_ready", 64'(in_ready), 64'd1);
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("abort_no_out_valid", 64'(seen), 64'd0);
      do_op("after_abort", 1'b1, 23'h0, 1'b1, 23'h0, 48'h400000000000, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_mul_booth_seq.md
FP_MUL_BOOTH_SEQ -- requirements
Module: fp_mul_booth_seq

Interface
REQ-001 Module SHALL have no parameters; all widths fixed as below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand pair present.
REQ-005 in_ready  output  1  block can accept operands (state IDLE and rst low).
REQ-006 frc_X  input  23  fraction of X.
REQ-007 frc_Y  input  23  fraction of Y.
REQ-008 hid_X  input  1  hidden bit of X (1 = normal, 0 = subnormal/zero exponent).
REQ-009 hid_Y  input  1  hidden bit of Y.
REQ-010 out_valid  output  1  frc_Z_full holds a completed product.
REQ-011 out_ready  input  1  downstream normaliser accepts product.
REQ-012 frc_Z_full  output  48  unsigned product {hid_X,frc_X} * {hid_Y,frc_Y}, fed to normalisation stage.
REQ-013 busy  output  1  high in CALC state.

Function
REQ-014 Operands SHALL be M = {hid_X,frc_X} and Q = {hid_Y,frc_Y}, both 24-bit unsigned.
REQ-015 Multiplication SHALL use radix-4 Booth recoding of Q zero-extended to 26 bits, giving 13 digits d_i in {-2,-1,0,+1,+2}, digit i from triple Q[2i+1:2i-1] with Q[-1]=0.
REQ-016 One digit SHALL be processed per cycle: accumulator (50-bit two's complement) += d_i*M << 2i; -2M and -M formed by inversion plus carry-in.
REQ-017 frc_Z_full SHALL equal accumulator[47:0] and SHALL be bit-exact with M*Q for all 2^48 operand combinations; accumulator[49:48] SHALL be 0 at completion.
REQ-018 FSM states: IDLE, CALC, DONE.
REQ-019 IDLE: in_ready=1; on in_valid&&in_ready edge, latch M and Q, clear accumulator, digit counter=0, go CALC.
REQ-020 CALC: each edge processes digit[counter], counter++; edge processing digit 12 goes DONE.
REQ-021 Latency: out_valid SHALL rise exactly 13 edges after the accepting edge, independent of operand values (no zero/early-out path).
REQ-022 DONE: out_valid=1; frc_Z_full SHALL stay stable while out_valid&&!out_ready, for any number of cycles.
REQ-023 On out_valid&&out_ready edge: out_valid drops, go IDLE; in_ready rises the following cycle (no same-cycle accept-and-complete).
REQ-024 Operand inputs SHALL be ignored outside the accepting edge; changes during CALC/DONE SHALL not affect the result.
REQ-025 in_valid while not in_ready SHALL be ignored; the upstream source holds it.
REQ-026 Digit counter SHALL be 4-bit and SHALL not wrap past 12.
REQ-027 hid_X=0 with frc_X=0 (or same for Y) SHALL produce frc_Z_full=0 with full latency.

Reset
REQ-028 While rst high: state IDLE, counter 0, accumulator 0, frc_Z_full=0, out_valid=0, busy=0, in_ready=0.
REQ-029 First cycle after rst deasserts: in_ready=1, out_valid=0.
REQ-030 rst asserted in CALC or DONE SHALL abort the operation; no out_valid for the aborted operands afterward.
REQ-031 rst SHALL take priority over in_valid and out_ready on the same edge.

Verification
REQ-032 hid=1,frc_X=0,hid=1,frc_Y=0 (1.0*1.0) -> after 13 edges out_valid=1, frc_Z_full=0x400000000000.
REQ-033 hid=1,frc_X=0x7FFFFF,hid=1,frc_Y=0x7FFFFF -> frc_Z_full=0xFFFFFE000001, bit47=1.
REQ-034 hid=1,frc_X=0x400000,hid=1,frc_Y=0x400000 (1.5*1.5) -> 0x900000000000; hid_X=1,frc_X=0,hid_Y=1,frc_Y=0x490FDB -> frc_Z_full[45:23]=0x490FDB, bit46=1.
REQ-035 hid_X=0,frc_X=0x2DF854,hid_Y=1,frc_Y=0x490FDB -> 0x2DF854*0xC90FDB exactly; hid_X=0,frc_X=0 -> 0.
REQ-036 out_ready held 0 for 5 cycles in DONE, frc_X toggled meanwhile -> out_valid and frc_Z_full unchanged; then out_ready=1 -> out_valid=0, in_ready=1 next cycle.
REQ-037 rst pulsed at counter=6 -> all outputs 0, in_ready=1 the cycle after release, no out_valid; next operation 1.0*1.0 -> correct result at 13 edges.
